// File: rtl/vlb_pkg.sv
// rtl/vlb_pkg.sv - shared types, constants and beam-x to source-address scaling for video_line_buffer
package vlb_pkg;

    localparam int VLB_SRC_PIX = 720;
    localparam int ADDR_W      = $clog2(VLB_SRC_PIX);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE,
        FULL
    } wr_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Nearest-neighbour source index for a destination x, held at the last stored pixel.
    function automatic logic [ADDR_W-1:0] scaled_addr(input logic [11:0] x, input int h_step,
                                                      input int src_pix);
        logic [47:0] prod;
        logic [31:0] idx;
        prod = {36'd0, x} * 48'(h_step);
        idx  = prod[47:16];
        if (idx > 32'(src_pix - 1)) idx = 32'(src_pix - 1);
        return idx[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/vlb_line_ram.sv
// rtl/vlb_line_ram.sv - two-bank simple dual-port line RAM with registered read
module vlb_line_ram
    import vlb_pkg::*;
#(
    parameter int DEPTH = VLB_SRC_PIX
) (
    input  logic              clk,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rgb24_t            wr_data,
    input  logic              we,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output rgb24_t            rd_data
);

    rgb24_t mem [2][DEPTH];

    // Read-before-write when both ports hit the same bank and address.
    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/video_line_buffer.sv
// rtl/video_line_buffer.sv - ping-pong line buffer feeding the HDMI beam; VLB_SCANLINE_EN halves odd destination lines
module video_line_buffer
    import vlb_pkg::*;
#(
    parameter int SRC_PIX   = VLB_SRC_PIX,
    parameter int SRC_HSKIP = 0,
    parameter int H_STEP    = 36864,
    parameter int LC_W      = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      i_src_r,
    input  logic [7:0]      i_src_g,
    input  logic [7:0]      i_src_b,
    input  logic            i_src_pix_en,
    input  logic            i_src_hsync,
    input  logic            i_src_vsync,
    input  logic [11:0]     i_x,
    input  logic [11:0]     i_y,
    input  logic            i_de,
    output logic [7:0]      o_r,
    output logic [7:0]      o_g,
    output logic [7:0]      o_b,
    output logic            o_frame_end,
    output logic [LC_W-1:0] o_line_count,
    output logic            o_overflow
);

    localparam wr_state_t LINE_START = (SRC_HSKIP == 0) ? CAPTURE : SKIP;

    wr_state_t         state, state_nx, line_state;
    logic              hs_q, vs_q, hs_edge, vs_edge;
    logic              wr_bank, valid, swap, we, over;
    logic [ADDR_W-1:0] wr_ptr, ptr_base, ptr_nx;
    logic [ADDR_W-1:0] skip_cnt, skip_base, skip_nx;

    assign hs_edge = i_src_hsync & ~hs_q;
    assign vs_edge = i_src_vsync & ~vs_q;

    // An hsync edge restarts the line first, so a coincident pixel lands in the new line.
    always_comb begin
        line_state = state;
        ptr_base   = wr_ptr;
        skip_base  = skip_cnt;
        swap       = 1'b0;
        if (hs_edge && state != IDLE) begin
            swap       = (wr_ptr != '0);
            line_state = LINE_START;
            ptr_base   = '0;
            skip_base  = '0;
        end
        state_nx = line_state;
        ptr_nx   = ptr_base;
        skip_nx  = skip_base;
        we       = 1'b0;
        over     = 1'b0;
        case (line_state)
            IDLE: if (vs_edge) state_nx = LINE_START;
            SKIP: if (i_src_pix_en) begin
                if (int'(skip_base) >= SRC_HSKIP - 1) begin
                    state_nx = CAPTURE;
                    skip_nx  = '0;
                end else begin
                    skip_nx = skip_base + ADDR_W'(1);
                end
            end
            CAPTURE: if (i_src_pix_en) begin
                we = 1'b1;
                if (ptr_base == ADDR_W'(SRC_PIX - 1)) state_nx = FULL;
                else ptr_nx = ptr_base + ADDR_W'(1);
            end
            FULL: over = i_src_pix_en;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            state        <= IDLE;
            wr_ptr       <= '0;
            skip_cnt     <= '0;
            wr_bank      <= 1'b0;
            valid        <= 1'b0;
            o_overflow   <= 1'b0;
            o_frame_end  <= 1'b0;
            o_line_count <= '0;
        end else begin
            hs_q        <= i_src_hsync;
            vs_q        <= i_src_vsync;
            state       <= state_nx;
            wr_ptr      <= ptr_nx;
            skip_cnt    <= skip_nx;
            valid       <= valid | swap;
            o_overflow  <= over;
            o_frame_end <= vs_edge && state != IDLE;
            if (swap) wr_bank <= ~wr_bank;
            if (vs_edge && state != IDLE) o_line_count <= '0;
            else if (swap && o_line_count != '1) o_line_count <= o_line_count + LC_W'(1);
        end
    end

    logic [ADDR_W-1:0] rd_addr;
    logic              de1, de2, dim;
    rgb24_t            q, pix;

    vlb_line_ram #(.DEPTH(SRC_PIX)) u_ram (
        .clk     (clk),
        .wr_bank (wr_bank ^ swap),
        .wr_addr (ptr_base),
        .wr_data ({i_src_r, i_src_g, i_src_b}),
        .we      (we),
        .rd_bank (~wr_bank),
        .rd_addr (rd_addr),
        .rd_data (q)
    );

`ifdef VLB_SCANLINE_EN
    logic y1, y2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y1 <= 1'b0;
            y2 <= 1'b0;
        end else begin
            y1 <= i_y[0];
            y2 <= y1;
        end
    end
    assign dim = y2;
    logic unused_y;
    assign unused_y = ^i_y[11:1];
`else
    assign dim = 1'b0;
    logic unused_y;
    assign unused_y = ^i_y;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr <= '0;
            de1     <= 1'b0;
            de2     <= 1'b0;
            pix     <= '0;
        end else begin
            rd_addr <= scaled_addr(i_x, H_STEP, SRC_PIX);
            de1     <= i_de;
            de2     <= de1;
            if (de2 && valid)
                pix <= dim ? rgb24_t'({1'b0, q.r[7:1], 1'b0, q.g[7:1], 1'b0, q.b[7:1]}) : q;
            else
                pix <= '0;
        end
    end

    assign o_r = pix.r;
    assign o_g = pix.g;
    assign o_b = pix.b;

endmodule

// File: doc/video_line_buffer.md
Name: video_line_buffer

Overview:
- Sits directly upstream of the HDMI timing generator. Captures the Amiga core's native pixel stream into a ping-pong line RAM.
- Serves RGB to the generator, addressed by the generator's beam position (x/y/de). Horizontal scaling is nearest-neighbour.
- Emits a one-clock frame-end pulse on source vsync, so the 720p frame locks to the PAL field.
- Single clock domain: source pixels arrive as enables on clk.

Parameters:
- SRC_PIX, 720, line RAM depth per bank; source pixels captured per line.
- SRC_HSKIP, 0, pixel enables ignored after each hsync edge (left-border trim).
- H_STEP, 36864, 16.16 source-per-destination step, i.e. SRC_PIX*65536/1280.
- LC_W, 10, width of the source line counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low (0 = reset)
- i_src_r  input  8  source red
- i_src_g  input  8  source green
- i_src_b  input  8  source blue
- i_src_pix_en  input  1  source pixel valid, one clk per pixel
- i_src_hsync  input  1  source hsync, active high
- i_src_vsync  input  1  source vsync, active high
- i_x  input  12  destination beam x (active region)
- i_y  input  12  destination beam y
- i_de  input  1  destination data enable, active high
- o_r  output  8  pixel red to generator
- o_g  output  8  pixel green to generator
- o_b  output  8  pixel blue to generator
- o_frame_end  output  1  one-clk pulse on rising edge of i_src_vsync
- o_line_count  output  LC_W  source lines completed in current field
- o_overflow  output  1  one-clk pulse per pixel dropped because the line is full

Behaviour:
- Reset (async assert, sync release): o_r/o_g/o_b=0, o_frame_end=0, o_line_count=0, o_overflow=0, FSM=IDLE, wr_bank=0, wr_ptr=0, skip_cnt=0, valid=0. RAM contents are not reset.
- Edge detect: hsync and vsync are registered once; edges act on the clk after the input rises.
- Write FSM:
  - IDLE -> SKIP on vsync edge.
  - SKIP: count pix_en up to SRC_HSKIP, then -> CAPTURE. With SRC_HSKIP=0 go straight to CAPTURE.
  - CAPTURE: each pix_en writes {r,g,b} to bank[wr_bank][wr_ptr] and increments wr_ptr. The write at wr_ptr=SRC_PIX-1 -> FULL.
  - FULL: each pix_en pulses o_overflow; nothing is written.
  - On any hsync edge from SKIP/CAPTURE/FULL: if wr_ptr>0 then toggle wr_bank, set valid=1, line_count++ (saturating). Always clear wr_ptr and skip_cnt, then -> SKIP.
- Vsync edge, any state except IDLE: o_frame_end=1 for one clk and line_count=0. No bank swap unless an hsync edge occurs in the same cycle.
- Simultaneous hsync and vsync edges: swap per hsync rule; line_count is zeroed, not incremented.
- pix_en coinciding with a handled hsync edge: belongs to the new line and counts toward skip/capture.
- Read pipeline, latency 3 clk:
  - S1 registers addr = (i_x*H_STEP)>>16, clamped to SRC_PIX-1, and registers de, y[0].
  - S2 reads bank[~wr_bank] (registered RAM read).
  - S3 registers output. Black (0) if de=0 or valid=0.
- The generator holds each pixel for 4 clk, so the 3-clk latency is hidden.
- Vertical scaling is time-based: each source line repeats on every destination line shown until the next swap. Tearing is accepted.

Optional Feature:
- Macro VLB_SCANLINE_EN.
- Defined: S3 outputs each channel >>1 when registered i_y[0]=1 (odd destination line).
- Undefined: channels pass unmodified; the y pipeline registers are removed.

Decomposition:
- Package vlb_pkg holds: FSM state enum (IDLE, SKIP, CAPTURE, FULL); RGB24 struct typedef; localparam ADDR_W=$clog2(SRC_PIX); a function for the clamp-scaled address.
- Sub-module vlb_line_ram: two banks of SRC_PIX x 24 simple dual-port RAM. One write port {bank,addr,data,we}, one read port {bank,addr}. Registered read, infers block RAM.

Test Plan:
1. Reset low mid-capture -> all outputs 0 immediately; after release, i_de=1 gives o_r=0 until the first hsync-terminated line.
2. vsync, then 720 pix_en with r=addr[7:0], then hsync. Drive i_x=640, i_de=1 -> o_r=104 (addr 360) 3 clk later. i_x=1279 -> o_r=207 (addr 719). i_x=0 -> o_r=0.
3. SRC_HSKIP=4: line of 10 pixels r=0..9 -> bank addr 0 holds 4 and addr 5 holds 9; o_line_count=1 after the hsync.
4. 725 pix_en in one line -> o_overflow pulses 5 times; addr 719 holds pixel 719; no wrap to addr 0.
5. vsync edge after 3 lines -> o_frame_end high exactly 1 clk, o_line_count=0. hsync+vsync in the same clk -> bank swaps, o_line_count=0, o_frame_end=1.
6. i_de=0 -> RGB=0 regardless of RAM. With VLB_SCANLINE_EN, pixel r=200 at i_y=3 -> o_r=100; at i_y=4 -> o_r=200.
